sequenciador_pc: RTL and testbench

- Fetch sequencer that owns the `pc` register's next-value input.
- Decides each cycle whether the program counter holds, increments, branches, calls, returns or halts.
- Handshakes with instruction memory, keeps a small return-address stack, and flags stack misuse.
- Sits between the control unit, the instruction memory and `pc`. It drives `pc.entrada` and reads back `pc.endereco`; `pc` loads on every clock edge.

---
 rtl/sequenciador_pc_pkg.sv | 36 +++
 rtl/sequenciador_pc_pilha_retorno.sv | 47 ++++
 rtl/sequenciador_pc.sv | 147 ++++++++++++++
 tb/tb_sequenciador_pc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_pc_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, default widths
// and the ranking of the control decisions taken when an instruction is valid.
package sequenciador_pc_pkg;

    localparam int LARGURA_PADRAO = 8;
    localparam logic [LARGURA_PADRAO-1:0] VETOR_RESET_PADRAO = 8'h00;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        AVANCA = 2'd2,
        PARADO = 2'd3
    } estado_e;

    // Lower value wins; the control unit reuses the same ranking.
    typedef enum logic [2:0] {
        DEC_PARAR      = 3'd0,
        DEC_RETORNO    = 3'd1,
        DEC_CHAMADA    = 3'd2,
        DEC_DESVIO     = 3'd3,
        DEC_INCREMENTA = 3'd4
    } decisao_e;

    // Resolves simultaneous control requests into the single winning decision.
    function automatic decisao_e decidir(input logic parar,
                                         input logic retorno,
                                         input logic chamada,
                                         input logic desvio);
        if (parar)        return DEC_PARAR;
        else if (retorno) return DEC_RETORNO;
        else if (chamada) return DEC_CHAMADA;
        else if (desvio)  return DEC_DESVIO;
        else              return DEC_INCREMENTA;
    endfunction

endpackage

// File: rtl/sequenciador_pc_pilha_retorno.sv
// Return-address LIFO. A push on a full stack or a pop on an empty one is
// dropped here; the sequencer decides whether that counts as an error.
module pilha_retorno #(
    parameter int LARGURA    = 8,
    parameter int PILHA_PROF = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [LARGURA-1:0]            dado,
    output logic [LARGURA-1:0]            topo,
    output logic                          cheia,
    output logic                          vazia,
    output logic [$clog2(PILHA_PROF):0]   ocupacao
);

    localparam int IW = $clog2(PILHA_PROF);
    localparam logic [IW:0] UM         = 1;
    localparam logic [IW:0] CAPACIDADE = (IW+1)'(PILHA_PROF);

    logic [LARGURA-1:0] mem_q [PILHA_PROF];
    logic [IW:0]        ocupacao_q;
    logic [IW:0]        ocupacaoMenos1;

    assign ocupacaoMenos1 = ocupacao_q - UM;
    assign topo           = mem_q[ocupacaoMenos1[IW-1:0]];
    assign cheia          = (ocupacao_q == CAPACIDADE);
    assign vazia          = (ocupacao_q == '0);
    assign ocupacao       = ocupacao_q;

    // Stack storage and occupancy; push has precedence, though the caller never issues both.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ocupacao_q <= '0;
            for (int i = 0; i < PILHA_PROF; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !cheia) begin
            mem_q[ocupacao_q[IW-1:0]] <= dado;
            ocupacao_q                <= ocupacao_q + UM;
        end else if (pop && !vazia) begin
            ocupacao_q <= ocupacaoMenos1;
        end
    end

endmodule

// File: rtl/sequenciador_pc.sv
// Fetch sequencer: drives the next value of the external pc register, runs the
// instruction-memory handshake and keeps the call/return stack.
module sequenciador_pc
    import sequenciador_pc_pkg::*;
#(
    parameter int                 LARGURA     = LARGURA_PADRAO,
    parameter logic [LARGURA-1:0] VETOR_RESET = VETOR_RESET_PADRAO,
    parameter int                 PILHA_PROF  = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [LARGURA-1:0]          pc_endereco,
    output logic [LARGURA-1:0]          pc_entrada,
    output logic                        busca_req,
    input  logic                        mem_pronta,
    output logic                        instrucao_valida,
    input  logic                        desvio_valido,
    input  logic                        chamada,
    input  logic                        retorno,
    input  logic [LARGURA-1:0]          desvio_alvo,
    input  logic                        parar,
    input  logic                        retomar,
    output logic                        parado,
    output logic                        erro_pilha,
    output logic [$clog2(PILHA_PROF):0] profundidade
);

    localparam logic [LARGURA-1:0] UM = 1;

    estado_e            estado_q;
    logic               busca_req_q;
    logic               instrucao_valida_q;
    logic               parado_q;
    logic               erro_q;
    logic               erro_d;
    logic [LARGURA-1:0] pc_d;
    logic [LARGURA-1:0] pcMais1;
    logic [LARGURA-1:0] topo;
    logic               push;
    logic               pop;
    logic               cheia;
    logic               vazia;
    decisao_e           decisao;

    assign pcMais1 = pc_endereco + UM;
    assign decisao = decidir(parar, retorno, chamada, desvio_valido);

    pilha_retorno #(
        .LARGURA    (LARGURA),
        .PILHA_PROF (PILHA_PROF)
    ) u_pilha (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .dado     (pcMais1),
        .topo     (topo),
        .cheia    (cheia),
        .vazia    (vazia),
        .ocupacao (profundidade)
    );

    // Next-PC selection and stack control; only AVANCA ever moves pc away from hold.
    always_comb begin
        pc_d   = pc_endereco;
        push   = 1'b0;
        pop    = 1'b0;
        erro_d = erro_q;
        case (estado_q)
            INICIO: pc_d = VETOR_RESET;
            AVANCA: begin
                case (decisao)
                    DEC_PARAR: pc_d = pcMais1;
                    DEC_RETORNO: begin
                        if (vazia) begin
                            pc_d   = pcMais1;
                            erro_d = 1'b1;
                        end else begin
                            pc_d = topo;
                            pop  = 1'b1;
                        end
                    end
                    DEC_CHAMADA: begin
                        pc_d = desvio_alvo;
                        if (cheia) erro_d = 1'b1;
                        else       push   = 1'b1;
                    end
                    DEC_DESVIO: pc_d = desvio_alvo;
                    default:    pc_d = pcMais1;
                endcase
            end
            default: pc_d = pc_endereco;
        endcase
    end

    // The vector is forced combinationally while reset is held so pc loads it at once.
    assign pc_entrada = reset_n ? pc_d : VETOR_RESET;

    // Fetch FSM; each output flag is registered alongside the state it belongs to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q           <= INICIO;
            busca_req_q        <= 1'b0;
            instrucao_valida_q <= 1'b0;
            parado_q           <= 1'b0;
            erro_q             <= 1'b0;
        end else begin
            erro_q <= erro_d;
            case (estado_q)
                INICIO: begin
                    estado_q    <= BUSCA;
                    busca_req_q <= 1'b1;
                end
                BUSCA: begin
                    if (mem_pronta) begin
                        estado_q           <= AVANCA;
                        busca_req_q        <= 1'b0;
                        instrucao_valida_q <= 1'b1;
                    end
                end
                AVANCA: begin
                    instrucao_valida_q <= 1'b0;
                    if (decisao == DEC_PARAR) begin
                        estado_q <= PARADO;
                        parado_q <= 1'b1;
                    end else begin
                        estado_q    <= BUSCA;
                        busca_req_q <= 1'b1;
                    end
                end
                default: begin
                    if (retomar) begin
                        estado_q    <= BUSCA;
                        parado_q    <= 1'b0;
                        busca_req_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busca_req        = busca_req_q;
    assign instrucao_valida = instrucao_valida_q;
    assign parado           = parado_q;
    assign erro_pilha       = erro_q;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Directed bench for the fetch sequencer; the pc register is modelled here.
module tb_sequenciador_pc;

    logic       clock;
    logic       reset_n;
    logic [7:0] pc_endereco;
    logic [7:0] pc_entrada;
    logic       busca_req;
    logic       mem_pronta;
    logic       instrucao_valida;
    logic       desvio_valido;
    logic       chamada;
    logic       retorno;
    logic [7:0] desvio_alvo;
    logic       parar;
    logic       retomar;
    logic       parado;
    logic       erro_pilha;
    logic [2:0] profundidade;

    int checks = 0;
    int errors = 0;

    sequenciador_pc dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pc_endereco      (pc_endereco),
        .pc_entrada       (pc_entrada),
        .busca_req        (busca_req),
        .mem_pronta       (mem_pronta),
        .instrucao_valida (instrucao_valida),
        .desvio_valido    (desvio_valido),
        .chamada          (chamada),
        .retorno          (retorno),
        .desvio_alvo      (desvio_alvo),
        .parar            (parar),
        .retomar          (retomar),
        .parado           (parado),
        .erro_pilha       (erro_pilha),
        .profundidade     (profundidade)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External pc register: loads pc_entrada on every rising edge.
    always @(posedge clock) pc_endereco <= pc_entrada;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives the control inputs that are sampled during AVANCA.
    task automatic applyStimulus(input logic desv, input logic cham, input logic ret,
                                 input logic par, input logic [7:0] alvo);
        desvio_valido = desv;
        chamada       = cham;
        retorno       = ret;
        parar         = par;
        desvio_alvo   = alvo;
    endtask

    // Steps to the next AVANCA cycle, bounded so a stuck FSM still reaches the summary.
    task automatic waitAvanca(input string tag);
        int n = 0;
        @(negedge clock);
        while (!instrucao_valida && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, ".valida"}, {31'd0, instrucao_valida}, 32'd1);
    endtask

    // Executes one instruction: checks current pc and chosen next pc, then clears controls.
    task automatic execInstr(input logic [7:0] expPc, input logic [7:0] expNext, input string tag);
        waitAvanca(tag);
        checkOutput({tag, ".pc"}, {24'd0, pc_endereco}, {24'd0, expPc});
        checkOutput({tag, ".next"}, {24'd0, pc_entrada}, {24'd0, expNext});
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n    = 1'b1;
        mem_pronta = 1'b1;
        retomar    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        reset_n = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst.pc_entrada", {24'd0, pc_entrada}, 32'h00);
        checkOutput("rst.busca_req", {31'd0, busca_req}, 32'd0);
        checkOutput("rst.valida", {31'd0, instrucao_valida}, 32'd0);
        checkOutput("rst.parado", {31'd0, parado}, 32'd0);
        checkOutput("rst.prof", {29'd0, profundidade}, 32'd0);
        checkOutput("rst.erro", {31'd0, erro_pilha}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("inicio.pc_entrada", {24'd0, pc_entrada}, 32'h00);
        checkOutput("inicio.busca_req", {31'd0, busca_req}, 32'd0);
        @(negedge clock);
        checkOutput("busca0.busca_req", {31'd0, busca_req}, 32'd1);
        checkOutput("busca0.valida", {31'd0, instrucao_valida}, 32'd0);

        $display("[TB] sequential fetch");
        execInstr(8'h00, 8'h01, "seq0");
        @(negedge clock);
        checkOutput("seq.gap_valida", {31'd0, instrucao_valida}, 32'd0);
        checkOutput("seq.gap_busca", {31'd0, busca_req}, 32'd1);
        @(posedge clock);
        #1;
        execInstr(8'h01, 8'h02, "seq1");
        execInstr(8'h02, 8'h03, "seq2");
        execInstr(8'h03, 8'h04, "seq3");
        execInstr(8'h04, 8'h05, "seq4");

        $display("[TB] memory wait states");
        mem_pronta = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("wait.busca_req", {31'd0, busca_req}, 32'd1);
            checkOutput("wait.pc_entrada", {24'd0, pc_entrada}, 32'h05);
            if (i == 3) mem_pronta = 1'b1;
        end
        execInstr(8'h05, 8'h06, "wait.adv");

        $display("[TB] branch and wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
        execInstr(8'h06, 8'h10, "br10");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        execInstr(8'h10, 8'hFF, "brFF");
        execInstr(8'hFF, 8'h00, "wrap");

        $display("[TB] call/return nesting");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
        execInstr(8'h00, 8'h02, "br02");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
        execInstr(8'h02, 8'h40, "call40");
        checkOutput("call40.prof", {29'd0, profundidade}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
        execInstr(8'h40, 8'h80, "call80");
        checkOutput("call80.prof", {29'd0, profundidade}, 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h80, 8'h41, "ret41");
        checkOutput("ret41.prof", {29'd0, profundidade}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h41, 8'h03, "ret03");
        checkOutput("ret03.prof", {29'd0, profundidade}, 32'd0);
        checkOutput("nest.erro", {31'd0, erro_pilha}, 32'd0);

        $display("[TB] stack misuse");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h50);
        execInstr(8'h03, 8'h50, "c1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h60);
        execInstr(8'h50, 8'h60, "c2");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h70);
        execInstr(8'h60, 8'h70, "c3");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h88);
        execInstr(8'h70, 8'h88, "c4");
        checkOutput("c4.prof", {29'd0, profundidade}, 32'd4);
        checkOutput("c4.erro", {31'd0, erro_pilha}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        execInstr(8'h88, 8'h99, "c5");
        checkOutput("c5.prof", {29'd0, profundidade}, 32'd4);
        checkOutput("c5.erro", {31'd0, erro_pilha}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h99, 8'h71, "r1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h71, 8'h61, "r2");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h61, 8'h51, "r3");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h51, 8'h04, "r4");
        checkOutput("r4.prof", {29'd0, profundidade}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        execInstr(8'h04, 8'h05, "rEmpty");
        checkOutput("rEmpty.prof", {29'd0, profundidade}, 32'd0);
        checkOutput("rEmpty.erro", {31'd0, erro_pilha}, 32'd1);

        $display("[TB] halt, priority and resume");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
        execInstr(8'h05, 8'h20, "br20");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h90);
        execInstr(8'h20, 8'h21, "halt");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h90);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("halt.parado", {31'd0, parado}, 32'd1);
            checkOutput("halt.pc_entrada", {24'd0, pc_entrada}, 32'h21);
            checkOutput("halt.busca_req", {31'd0, busca_req}, 32'd0);
            if (i == 4) retomar = 1'b1;
        end
        checkOutput("halt.prof", {29'd0, profundidade}, 32'd0);
        @(posedge clock);
        #1;
        retomar = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("resume.parado", {31'd0, parado}, 32'd0);
        checkOutput("resume.busca_req", {31'd0, busca_req}, 32'd1);
        checkOutput("resume.pc", {24'd0, pc_endereco}, 32'h21);
        execInstr(8'h21, 8'h22, "resume.adv");
        checkOutput("resume.erro", {31'd0, erro_pilha}, 32'd1);

        $display("[TB] reset during halt");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        execInstr(8'h22, 8'h23, "halt2");
        @(negedge clock);
        checkOutput("halt2.parado", {31'd0, parado}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst2.parado", {31'd0, parado}, 32'd0);
        checkOutput("rst2.pc_entrada", {24'd0, pc_entrada}, 32'h00);
        checkOutput("rst2.erro", {31'd0, erro_pilha}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("rst2.inicio_busca", {31'd0, busca_req}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("rst2.busca_req", {31'd0, busca_req}, 32'd1);
        checkOutput("rst2.valida", {31'd0, instrucao_valida}, 32'd0);
        execInstr(8'h00, 8'h01, "rst2.adv");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
